// File: rtl/voice_allocator.sv
// voice_allocator: registers raw key levels, derives press pulses and the
// lowest held key, and assigns pressed keys to a small pool of voice slots.
// One key is allocated per cycle (lowest index first) to the lowest idle
// voice. Define VOICE_STEAL_EN to let a candidate take the oldest voice
// when every voice is busy; by default it waits for a voice to free up.
module voice_allocator #(
  parameter int unsigned NUM_KEYS   = 24,
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_W      = 16,
  localparam int unsigned KEY_W     = $clog2(NUM_KEYS)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [NUM_KEYS-1:0]         touch_status_in,
  output logic [NUM_KEYS-1:0]         gate_out,
  output logic [NUM_KEYS-1:0]         trigger_out,
  output logic [KEY_W-1:0]            note_sel_out,
  output logic                        note_valid_out,
  output logic [NUM_VOICES-1:0]       voice_active_out,
  output logic [NUM_VOICES*KEY_W-1:0] voice_note_out,
  output logic [NUM_VOICES-1:0]       voice_trig_out,
  output logic                        voices_full_out
);

  localparam int unsigned VOICE_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned KEY_SPAN = 1 << KEY_W;

  logic [NUM_KEYS-1:0]   gate_q;
  logic [NUM_KEYS-1:0]   gate_prev_q;
  logic [NUM_KEYS-1:0]   pending_q, pending_d;
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [NUM_VOICES-1:0] vtrig_q, vtrig_d;
  logic [KEY_W-1:0]      note_q [NUM_VOICES];
  logic [KEY_W-1:0]      note_d [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];
  logic [AGE_W-1:0]      age_d  [NUM_VOICES];

  logic [NUM_KEYS-1:0]   trigger;
  logic [NUM_KEYS-1:0]   cand;
  logic [KEY_SPAN-1:0]   gate_wide;
  logic                  cand_found;
  logic [KEY_W-1:0]      cand_idx;
  logic                  free_found;
  logic [VOICE_W-1:0]    free_idx;
  logic                  target_found;
  logic [VOICE_W-1:0]    target_idx;
  logic                  alloc;

  assign trigger   = gate_q & ~gate_prev_q;
  assign cand      = (pending_q | trigger) & gate_q;
  // Zero-extended so a stored note index can address it without range issues.
  assign gate_wide = KEY_SPAN'(gate_q);
  assign alloc     = cand_found & target_found;

  assign gate_out         = gate_q;
  assign trigger_out      = trigger;
  assign voice_active_out = active_q;
  assign voice_trig_out   = vtrig_q;
  assign voices_full_out  = &active_q;

  // Lowest-numbered held key for the monophonic note output.
  always_comb begin
    note_sel_out   = '0;
    note_valid_out = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (gate_q[i] && !note_valid_out) begin
        note_valid_out = 1'b1;
        note_sel_out   = KEY_W'(i);
      end
    end
  end

  // Lowest-index candidate key awaiting a voice.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (cand[i] && !cand_found) begin
        cand_found = 1'b1;
        cand_idx   = KEY_W'(i);
      end
    end
  end

  // Target voice: lowest idle slot, or the oldest slot when stealing.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (!active_q[v] && !free_found) begin
        free_found = 1'b1;
        free_idx   = VOICE_W'(v);
      end
    end
    target_found = free_found;
    target_idx   = free_idx;
`ifdef VOICE_STEAL_EN
    begin : steal_pick
      logic [VOICE_W-1:0] old_idx;
      logic [AGE_W-1:0]   old_age;
      old_idx = '0;
      old_age = age_q[0];
      // Strict compare keeps ties on the lowest index.
      for (int unsigned v = 1; v < NUM_VOICES; v++) begin
        if (age_q[v] > old_age) begin
          old_age = age_q[v];
          old_idx = VOICE_W'(v);
        end
      end
      if (!free_found) begin
        target_found = 1'b1;
        target_idx   = old_idx;
      end
    end
`endif
  end

  // Voice bookkeeping: ageing and release first, then allocation overrides
  // so a voice released and reassigned in the same cycle stays active.
  always_comb begin
    pending_d = cand;
    active_d  = active_q;
    vtrig_d   = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      note_d[v] = note_q[v];
      age_d[v]  = age_q[v];
      if (active_q[v]) begin
        if (age_q[v] != '1) begin
          age_d[v] = age_q[v] + 1'b1;
        end
        if (!gate_wide[note_q[v]]) begin
          active_d[v] = 1'b0;
        end
      end
    end
    if (alloc) begin
      pending_d[cand_idx]  = 1'b0;
      active_d[target_idx] = 1'b1;
      note_d[target_idx]   = cand_idx;
      age_d[target_idx]    = '0;
      vtrig_d[target_idx]  = 1'b1;
    end
  end

  // Packed view of the per-voice note registers.
  always_comb begin
    voice_note_out = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      voice_note_out[v*KEY_W +: KEY_W] = note_q[v];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      gate_q      <= '0;
      gate_prev_q <= '0;
      pending_q   <= '0;
      active_q    <= '0;
      vtrig_q     <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      gate_q      <= touch_status_in;
      gate_prev_q <= gate_q;
      pending_q   <= pending_d;
      active_q    <= active_d;
      vtrig_q     <= vtrig_d;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= note_d[v];
        age_q[v]  <= age_d[v];
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: voice assignments are predicted
// into a scoreboard when keys are driven and matched against voice_trig_out.
module tb_voice_allocator;

  localparam int NK = 24;
  localparam int NV = 4;
  localparam int KW = $clog2(NK);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NK-1:0]     touch = '0;
  logic [NK-1:0]     gate_out, trigger_out;
  logic [KW-1:0]     note_sel_out;
  logic              note_valid_out;
  logic [NV-1:0]     voice_active_out, voice_trig_out;
  logic [NV*KW-1:0]  voice_note_out;
  logic              voices_full_out;

  typedef struct {
    int voice;
    int note;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  voice_allocator #(
    .NUM_KEYS   (NK),
    .NUM_VOICES (NV),
    .AGE_W      (16)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .touch_status_in  (touch),
    .gate_out         (gate_out),
    .trigger_out      (trigger_out),
    .note_sel_out     (note_sel_out),
    .note_valid_out   (note_valid_out),
    .voice_active_out (voice_active_out),
    .voice_note_out   (voice_note_out),
    .voice_trig_out   (voice_trig_out),
    .voices_full_out  (voices_full_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  function automatic int vnote(input int v);
    return int'(voice_note_out[v*KW +: KW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int v, input int n, input int c);
    exp_t e;
    e.voice = v;
    e.note  = n;
    e.cyc   = c;
    sb.push_back(e);
  endtask

  // Scoreboard: every voice_trig pulse must match the next predicted allocation.
  always @(negedge clk) begin
    exp_t e;
    for (int v = 0; v < NV; v++) begin
      if (voice_trig_out[v] === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: voice %0d note %0d pulsed at cycle %0d, none expected",
                   v, vnote(v), cyc);
        end else begin
          e = sb.pop_front();
          if (e.voice != v || e.note != vnote(v) || e.cyc != cyc) begin
            errors++;
            $display("FAIL sb_alloc: got voice %0d note %0d cycle %0d, expected voice %0d note %0d cycle %0d",
                     v, vnote(v), cyc, e.voice, e.note, e.cyc);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    touch = '0;
    tick();
    tick();
    checks++;
    if (gate_out !== '0 || trigger_out !== '0) begin
      errors++;
      $display("FAIL reset_gate: gate %h trig %h, expected 0 0", gate_out, trigger_out);
    end
    checks++;
    if (voice_active_out !== '0 || voice_trig_out !== '0 || voices_full_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_voice: active %b trig %b full %b, expected 0 0 0",
               voice_active_out, voice_trig_out, voices_full_out);
    end
    checks++;
    if (voice_note_out !== '0) begin
      errors++;
      $display("FAIL reset_notes: %h, expected 0", voice_note_out);
    end
    checks++;
    if (note_sel_out !== '0 || note_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_notesel: sel %0d valid %b, expected 0 0", note_sel_out, note_valid_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_press();
    logic [NK-1:0] m;
    m = '0;
    m[5] = 1'b1;
    touch = m;
    push_exp(0, 5, cyc + 2);
    tick();
    checks++;
    if (trigger_out !== m || gate_out !== m || voice_active_out !== '0) begin
      errors++;
      $display("FAIL single_trig: trig %h gate %h active %b, expected %h %h 0",
               trigger_out, gate_out, voice_active_out, m, m);
    end
    tick();
    checks++;
    if (voice_active_out !== 4'b0001 || vnote(0) != 5) begin
      errors++;
      $display("FAIL single_voice: active %b note %0d, expected 0001 5", voice_active_out, vnote(0));
    end
    checks++;
    if (note_sel_out !== 5 || note_valid_out !== 1'b1 || trigger_out !== '0) begin
      errors++;
      $display("FAIL single_notesel: sel %0d valid %b trig %h, expected 5 1 0",
               note_sel_out, note_valid_out, trigger_out);
    end
    touch = '0;
    repeat (3) tick();
  endtask

  task automatic test_release();
    touch = '0;
    touch[7] = 1'b1;
    push_exp(0, 7, cyc + 2);
    tick();
    tick();
    touch = '0;
    tick();
    checks++;
    if (voice_active_out !== 4'b0001) begin
      errors++;
      $display("FAIL release_hold: active %b one cycle after fall, expected 0001", voice_active_out);
    end
    tick();
    checks++;
    if (voice_active_out !== 4'b0000 || vnote(0) != 7) begin
      errors++;
      $display("FAIL release_drop: active %b note %0d, expected 0000 7", voice_active_out, vnote(0));
    end
    repeat (2) tick();
  endtask

  task automatic test_simultaneous();
    int c;
    c = cyc;
    touch = '0;
    touch[3] = 1'b1;
    touch[9] = 1'b1;
    push_exp(0, 3, c + 2);
    push_exp(1, 9, c + 3);
    tick();
    tick();
    checks++;
    if (voice_active_out !== 4'b0001 || note_sel_out !== 3) begin
      errors++;
      $display("FAIL simul_first: active %b sel %0d, expected 0001 3", voice_active_out, note_sel_out);
    end
    tick();
    checks++;
    if (voice_active_out !== 4'b0011 || vnote(1) != 9) begin
      errors++;
      $display("FAIL simul_second: active %b note1 %0d, expected 0011 9", voice_active_out, vnote(1));
    end
    touch = '0;
    repeat (3) tick();
    checks++;
    if (voice_active_out !== '0) begin
      errors++;
      $display("FAIL simul_clear: active %b, expected 0000", voice_active_out);
    end
  endtask

  task automatic test_overflow();
    int r;
    for (int k = 0; k < 5; k++) begin
      touch[k] = 1'b1;
      if (k < 4) push_exp(k, k, cyc + 2);
`ifdef VOICE_STEAL_EN
      if (k == 4) push_exp(0, 4, cyc + 2);
`endif
      tick();
    end
    checks++;
    if (voices_full_out !== 1'b1 || voice_active_out !== 4'b1111) begin
      errors++;
      $display("FAIL overflow_full: full %b active %b, expected 1 1111", voices_full_out, voice_active_out);
    end
`ifdef VOICE_STEAL_EN
    tick();
    checks++;
    if (vnote(0) != 4 || vnote(1) != 1 || vnote(2) != 2 || vnote(3) != 3) begin
      errors++;
      $display("FAIL overflow_steal: notes %0d %0d %0d %0d, expected 4 1 2 3",
               vnote(0), vnote(1), vnote(2), vnote(3));
    end
`else
    repeat (3) tick();
    checks++;
    if (voice_active_out !== 4'b1111 || vnote(0) != 0 || vnote(1) != 1 || vnote(2) != 2 || vnote(3) != 3) begin
      errors++;
      $display("FAIL overflow_wait: active %b notes %0d %0d %0d %0d, expected 1111 0 1 2 3",
               voice_active_out, vnote(0), vnote(1), vnote(2), vnote(3));
    end
    touch[1] = 1'b0;
    r = cyc;
    push_exp(1, 4, r + 3);
    tick();
    tick();
    checks++;
    if (voice_active_out !== 4'b1101) begin
      errors++;
      $display("FAIL overflow_free: active %b, expected 1101", voice_active_out);
    end
    tick();
    checks++;
    if (voice_active_out !== 4'b1111 || vnote(1) != 4) begin
      errors++;
      $display("FAIL overflow_take: active %b note1 %0d, expected 1111 4", voice_active_out, vnote(1));
    end
`endif
    touch = '0;
    repeat (4) tick();
    checks++;
    if (voice_active_out !== '0) begin
      errors++;
      $display("FAIL overflow_clear: active %b, expected 0000", voice_active_out);
    end
  endtask

  task automatic test_short_press();
    int c;
    int p;
    logic [NK-1:0] m;
    c = cyc;
    touch = '0;
    for (int k = 0; k < 4; k++) begin
      touch[k] = 1'b1;
      push_exp(k, k, c + 2 + k);
    end
    repeat (6) tick();
    p = cyc;
    touch[7] = 1'b1;
`ifdef VOICE_STEAL_EN
    push_exp(0, 7, p + 2);
`endif
    tick();
    m = 24'h00000f;
    m[7] = 1'b1;
    checks++;
    if (trigger_out !== 24'h000080 || gate_out !== m) begin
      errors++;
      $display("FAIL short_trig: trig %h gate %h, expected 000080 %h", trigger_out, gate_out, m);
    end
    touch[7] = 1'b0;
    tick();
    tick();
`ifdef VOICE_STEAL_EN
    checks++;
    if (voice_active_out !== 4'b1110) begin
      errors++;
      $display("FAIL short_steal: active %b, expected 1110", voice_active_out);
    end
`else
    checks++;
    if (voice_active_out !== 4'b1111 || vnote(0) != 0) begin
      errors++;
      $display("FAIL short_full: active %b note0 %0d, expected 1111 0", voice_active_out, vnote(0));
    end
`endif
    touch[0] = 1'b0;
    repeat (4) tick();
    checks++;
    if (voice_active_out !== 4'b1110) begin
      errors++;
      $display("FAIL short_never: active %b, expected 1110", voice_active_out);
    end
    touch = '0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    int c;
    int q;
    logic [NK-1:0] m;
    m = '0;
    m[10] = 1'b1;
    m[11] = 1'b1;
    m[12] = 1'b1;
    c = cyc;
    touch = m;
    push_exp(0, 10, c + 2);
    push_exp(1, 11, c + 3);
    push_exp(2, 12, c + 4);
    repeat (5) tick();
    checks++;
    if (voice_active_out !== 4'b0111) begin
      errors++;
      $display("FAIL mid_before: active %b, expected 0111", voice_active_out);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (gate_out !== '0 || trigger_out !== '0 || note_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_gate: gate %h trig %h valid %b, expected 0 0 0",
               gate_out, trigger_out, note_valid_out);
    end
    checks++;
    if (voice_active_out !== '0 || voice_note_out !== '0 || voice_trig_out !== '0) begin
      errors++;
      $display("FAIL mid_voice: active %b notes %h trig %b, expected 0 0 0",
               voice_active_out, voice_note_out, voice_trig_out);
    end
    rst_n = 1'b1;
    q = cyc;
    push_exp(0, 10, q + 2);
    push_exp(1, 11, q + 3);
    push_exp(2, 12, q + 4);
    tick();
    checks++;
    if (trigger_out !== m) begin
      errors++;
      $display("FAIL mid_retrig: trig %h, expected %h", trigger_out, m);
    end
    repeat (3) tick();
    checks++;
    if (voice_active_out !== 4'b0111 || vnote(2) != 12) begin
      errors++;
      $display("FAIL mid_after: active %b note2 %0d, expected 0111 12", voice_active_out, vnote(2));
    end
    touch = '0;
    repeat (3) tick();
  endtask

  task automatic test_drain();
    int budget;
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected allocations never seen, expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_release();
    test_simultaneous();
    test_overflow();
    test_short_press();
    test_reset_mid();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
